// File: rtl/tick_bcd_counter.sv
// Multi-digit BCD up/down counter stepped by rising edges of div_n_clk.
// Define TICK_SYNC_EN to pass div_n_clk through a 2-flop synchronizer.
module tick_bcd_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  org_clk,
  input  logic                  sys_rst_n,
  input  logic                  div_n_clk,
  input  logic                  cnt_en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  step,
  output logic                  wrap
);

  localparam int W = 4 * DIGITS;

  logic         sample;
  logic         edge_det;
  logic         div_prev_q, div_prev_d;
  logic [W-1:0] bcd_q, bcd_d;
  logic         step_q, step_d;
  logic         wrap_q, wrap_d;
  logic [W-1:0] inc_val;
  logic [W-1:0] clamp_val;
  logic         ripple;

`ifdef TICK_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], div_n_clk};
  end

  always_ff @(posedge org_clk) begin
    if (!sys_rst_n) sync_q <= 2'b11;
    else            sync_q <= sync_d;
  end

  assign sample = sync_q[1];
`else
  assign sample = div_n_clk;
`endif

  assign edge_det = sample & ~div_prev_q;

  // Ripple stops at the first digit that does not roll over;
  // a ripple surviving the top digit is the wrap.
  always_comb begin
    inc_val   = bcd_q;
    clamp_val = load_val;
    ripple    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) clamp_val[4*i +: 4] = 4'd9;
      if (ripple) begin
        if (up_dn) begin
          if (bcd_q[4*i +: 4] >= 4'd9) begin
            inc_val[4*i +: 4] = 4'd0;
          end else begin
            inc_val[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            ripple            = 1'b0;
          end
        end else begin
          if (bcd_q[4*i +: 4] == 4'd0) begin
            inc_val[4*i +: 4] = 4'd9;
          end else begin
            inc_val[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
            ripple            = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    bcd_d      = bcd_q;
    step_d     = 1'b0;
    wrap_d     = 1'b0;
    div_prev_d = sample;
    if (load) begin
      bcd_d = clamp_val;
    end else if (edge_det && cnt_en) begin
      bcd_d  = inc_val;
      step_d = 1'b1;
      wrap_d = ripple;
    end
  end

  always_ff @(posedge org_clk) begin
    if (!sys_rst_n) begin
      bcd_q      <= '0;
      step_q     <= 1'b0;
      wrap_q     <= 1'b0;
      div_prev_q <= 1'b1;
    end else begin
      bcd_q      <= bcd_d;
      step_q     <= step_d;
      wrap_q     <= wrap_d;
      div_prev_q <= div_prev_d;
    end
  end

  assign bcd_out = bcd_q;
  assign step    = step_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed self-checking bench for tick_bcd_counter (DIGITS=4).
// Edge latency follows TICK_SYNC_EN (3 cycles) or default (1 cycle).
module tb_tick_bcd_counter;

`ifdef TICK_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        div;
  logic        en;
  logic        up;
  logic        ld;
  logic [15:0] lv;
  logic [15:0] bcd;
  logic        step;
  logic        wrap;

  int errors = 0;
  int checks = 0;
  int nstep;
  int nwrap;

  tick_bcd_counter #(.DIGITS(4)) dut (
    .org_clk   (clk),
    .sys_rst_n (rst_n),
    .div_n_clk (div),
    .cnt_en    (en),
    .up_dn     (up),
    .load      (ld),
    .load_val  (lv),
    .bcd_out   (bcd),
    .step      (step),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic rise();
    div = 1'b1;
    repeat (LAT) tick();
  endtask

  task automatic fall();
    div = 1'b0;
    repeat (LAT) tick();
  endtask

  task automatic do_load(input logic [15:0] v);
    ld = 1'b1;
    lv = v;
    tick();
    ld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    div   = 1'b0;
    en    = 1'b1;
    up    = 1'b1;
    ld    = 1'b0;
    lv    = '0;
    repeat (2) tick();
    check("rst_bcd", {16'd0, bcd}, 32'h0);
    check("rst_step", {31'd0, step}, 32'd0);
    check("rst_wrap", {31'd0, wrap}, 32'd0);
    rst_n = 1'b1;

    // divide-by-4 source: five rising edges
    nstep = 0;
    nwrap = 0;
    for (int c = 0; c < 20; c++) begin
      div = ((c % 4) >= 2);
      tick();
      nstep += int'(step);
      nwrap += int'(wrap);
    end
    div = 1'b0;
    repeat (4) begin
      tick();
      nstep += int'(step);
      nwrap += int'(wrap);
    end
    check("div4_bcd", {16'd0, bcd}, 32'h0005);
    check("div4_steps", nstep, 5);
    check("div4_wraps", nwrap, 0);

    // up wrap
    do_load(16'h9998);
    check("ld_9998", {16'd0, bcd}, 32'h9998);
    check("ld_step", {31'd0, step}, 32'd0);
    rise();
    check("up1_bcd", {16'd0, bcd}, 32'h9999);
    check("up1_step", {31'd0, step}, 32'd1);
    check("up1_wrap", {31'd0, wrap}, 32'd0);
    fall();
    check("up1_step_low", {31'd0, step}, 32'd0);
    rise();
    check("up2_bcd", {16'd0, bcd}, 32'h0000);
    check("up2_wrap", {31'd0, wrap}, 32'd1);
    fall();
    check("up2_wrap_low", {31'd0, wrap}, 32'd0);

    // down wrap
    do_load(16'h0001);
    up = 1'b0;
    rise();
    check("dn1_bcd", {16'd0, bcd}, 32'h0000);
    check("dn1_wrap", {31'd0, wrap}, 32'd0);
    fall();
    rise();
    check("dn2_bcd", {16'd0, bcd}, 32'h9999);
    check("dn2_wrap", {31'd0, wrap}, 32'd1);
    check("dn2_step", {31'd0, step}, 32'd1);
    fall();
    up = 1'b1;

    // load coincident with edge, clamped digit
    div = 1'b1;
    repeat (LAT - 1) tick();
    do_load(16'h12A4);
    check("ldcoin_bcd", {16'd0, bcd}, 32'h1294);
    check("ldcoin_step", {31'd0, step}, 32'd0);
    repeat (LAT) tick();
    check("ldcoin_hold", {16'd0, bcd}, 32'h1294);
    fall();
    rise();
    check("ldcoin_next", {16'd0, bcd}, 32'h1295);
    fall();

    // reset mid-count
    do_load(16'h0042);
    check("ld_0042", {16'd0, bcd}, 32'h0042);
    rst_n = 1'b0;
    div   = 1'b1;
    tick();
    rst_n = 1'b1;
    check("midrst_bcd", {16'd0, bcd}, 32'h0000);

    // div high through reset release: no step
    nstep = 0;
    repeat (LAT + 3) begin
      tick();
      nstep += int'(step);
    end
    check("hi_rel_steps", nstep, 0);
    check("hi_rel_bcd", {16'd0, bcd}, 32'h0000);
    fall();
    rise();
    check("first_edge", {16'd0, bcd}, 32'h0001);
    check("first_step", {31'd0, step}, 32'd1);
    fall();

    // dropped edge while disabled
    en = 1'b0;
    rise();
    check("dis_step", {31'd0, step}, 32'd0);
    check("dis_bcd", {16'd0, bcd}, 32'h0001);
    fall();
    en = 1'b1;
    rise();
    check("en_bcd", {16'd0, bcd}, 32'h0002);

    // latency measurement from div rise to step
    fall();
    div = 1'b1;
    nstep = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (step && nstep == 0) nstep = c;
    end
    check("latency", nstep, LAT);
    div = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_bcd_counter.md
# tick_bcd_counter

Multi-digit BCD up/down counter advanced by rising edges of the divided clock level `div_n_clk` from the upstream even frequency divider. Runs entirely in the `org_clk` domain and treats `div_n_clk` as a data input, never as a clock. Produces packed BCD digits for the display stage downstream, plus per-step and wrap pulses.

## Interface
- `DIGITS`, default 4: number of BCD digits; legal range 1..8.
- `org_clk`  in  1: system clock; all flops on its rising edge.
- `sys_rst_n`  in  1: synchronous active-low reset, sampled on `org_clk` rising edge.
- `div_n_clk`  in  1: divided clock level from the divider; sampled as data.
- `cnt_en`  in  1: when 1, detected edges advance the count; when 0, edges are dropped.
- `up_dn`  in  1: 1 = count up, 0 = count down; sampled in the step cycle.
- `load`  in  1: synchronous parallel load of `load_val`.
- `load_val`  in  4*DIGITS: packed BCD load value; digit 0 in bits [3:0].
- `bcd_out`  out  4*DIGITS: registered packed BCD count.
- `step`  out  1: registered 1-cycle pulse when a count step is applied.
- `wrap`  out  1: registered 1-cycle pulse when a step wraps (9..9→0..0 up, 0..0→9..9 down).

## Operation
- Edge detector: register `div_prev` holds the previous sample of the (optionally synchronized) `div_n_clk`. `edge = sample & ~div_prev`.
- `div_prev` resets to 1. A high `div_n_clk` at reset release is never counted; the first counted edge is the first 0→1 transition after reset.
- Per-cycle priority, highest first:
  - reset: `bcd_out` = 0, `step` = 0, `wrap` = 0, `div_prev` = 1, sync flops = 1.
  - `load`: `bcd_out` ← `load_val`, with any digit >9 clamped to 9. `step` = 0 and `wrap` = 0. A coincident edge is discarded.
  - `edge & cnt_en`: apply one step and set `step` = 1 for one cycle.
  - otherwise: hold the count; `step` = 0 and `wrap` = 0.
- Step arithmetic, per-digit BCD with ripple carry/borrow:
  - Up: digit 9 → 0 and carries into the next digit.
  - Down: digit 0 → 9 and borrows from the next digit.
  - Carry out of the top digit (up) or borrow out of it (down) sets `wrap` = 1 in the same cycle as `step`.
- Edges are not queued: an edge with `cnt_en` = 0 is lost.
- `div_prev` updates every non-reset cycle, including load cycles.
- Only one edge is possible per two `org_clk` cycles. A `div_n_clk` high for one cycle still yields exactly one step.

## Timing
- Without the macro: a 0→1 on `div_n_clk` sampled at edge k updates `bcd_out`, `step` and `wrap` at edge k, visible in cycle k+1. Latency is 1 cycle.
- With the macro: latency is 3 cycles (2 sync stages plus 1).
- Load latency is 1 cycle regardless of the macro.
- `step` and `wrap` never stay high for two consecutive cycles.
- Reset mid-count wins unconditionally; the count restarts from 0.
- Reset release while `div_n_clk` = 1: no step until `div_n_clk` falls and rises again.

## Configuration
- `TICK_SYNC_EN` defined: `div_n_clk` passes through a 2-flop synchronizer (both flops reset to 1) before the edge detector. Use this when the upstream divider sits in another clock domain.
- `TICK_SYNC_EN` undefined: `div_n_clk` feeds the edge detector directly. This is legal only when the divider is clocked by the same `org_clk`.

## Test plan
- DIGITS=4, `cnt_en`=1, `up_dn`=1, `div_n_clk` from a divider with N=4 (period 4 cycles): after 5 rising edges `bcd_out` = 0x0005, one `step` pulse per 4 cycles, `wrap` never set.
- Load 0x9998, count up 2 edges: `bcd_out` = 0x9999 then 0x0000; `wrap` = 1 only on the second step.
- Load 0x0001, `up_dn`=0, 2 edges: `bcd_out` = 0x0000 then 0x9999; `wrap` = 1 on the second step.
- `load`=1 in the same cycle as an edge, `load_val`=0x12A4: `bcd_out` = 0x1294 (digit clamped); `step` = 0; the following edge gives 0x1295.
- Hold `div_n_clk`=1 through reset and release: no step. Toggle `cnt_en`=0 across one edge: that edge is dropped and the count is unchanged.
- Assert `sys_rst_n`=0 for 1 cycle mid-count at 0x0042: `bcd_out` = 0x0000 next cycle. With `TICK_SYNC_EN`, the first-step latency measures 3 cycles.
